instr_fetch_queue: RTL

- Consumer end of the program-counter fetch path.
- Takes the current PC address, issues reads to a synchronous instruction memory (1-cycle read latency), and buffers returned {addr, instr} pairs in a small FIFO.
- Presents the buffered pairs to decode with a valid/ready handshake.
- Generates the PC advance enable and supports pipeline flush on redirect.

---
 rtl/ifq_pkg.sv | 20 ++
 rtl/instr_fetch_queue_if.sv | 37 +++
 rtl/ifq_fifo.sv | 81 ++++++++
 rtl/instr_fetch_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants, entry layout and pointer-width helper for the
// instruction fetch queue.
package ifq_pkg;

  localparam int IFQ_ADDR_W = 12;
  localparam int IFQ_DATA_W = 32;
  localparam int IFQ_DEPTH  = 4;

  // One buffered fetch result: the address it was read from and the word.
  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] addr;
    logic [IFQ_DATA_W-1:0] instr;
  } ifq_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ifq_clog2(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: PC, IMEM and decode-side signals of the fetch queue.
//
// Handshake: a head entry transfers to decode on every rising edge where
// out_valid and out_ready are both high. out_valid never depends on
// out_ready; out_ready is ignored while out_valid is low. The IMEM side is a
// fixed-latency strobe: imem_rdata is valid exactly one cycle after imem_rd.
interface instr_fetch_queue_if
  import ifq_pkg::*;
#(
  parameter int ADDR_W_IMEM = IFQ_ADDR_W,
  parameter int DATA_W      = IFQ_DATA_W
);

  logic [ADDR_W_IMEM-1:0] pc_addr;
  logic                   pc_en;
  logic                   flush;
  logic                   imem_rd;
  logic [ADDR_W_IMEM-1:0] imem_addr;
  logic [DATA_W-1:0]      imem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_instr;
  logic [ADDR_W_IMEM-1:0] out_addr;

  // Fetch queue side
  modport slave (
    input  pc_addr, flush, imem_rdata, out_ready,
    output pc_en, imem_rd, imem_addr, out_valid, out_instr, out_addr
  );

  // PC / IMEM / decode side
  modport master (
    output pc_addr, flush, imem_rdata, out_ready,
    input  pc_en, imem_rd, imem_addr, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO of fetch entries with push/pop, occupancy
// count and full/empty flags. clr empties it in one cycle.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int DEPTH = IFQ_DEPTH,
  localparam int PW    = ifq_clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  ifq_entry_t push_data,
  input  logic       pop,
  output ifq_entry_t head,
  output logic [PW:0] count,
  output logic       full,
  output logic       empty
);

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          pop_eff;

  // Next-state for pointers, count and storage; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_eff  = pop & (count_q != '0);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop_eff})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Flags and head view.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
    full  = (count_q == (PW+1)'(DEPTH));
    empty = (count_q == '0);
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: issues one IMEM read per cycle while credit allows,
// captures the 1-cycle-latency response with its address, buffers it and
// hands it to decode. flush drops the queue and the in-flight read.
// Build macro IFQ_BYPASS_EN: when the queue is empty a returning response
// is shown to decode in the same cycle (and skips the queue if accepted).
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int ADDR_W_IMEM = IFQ_ADDR_W,
  parameter int DATA_W      = IFQ_DATA_W,
  parameter int DEPTH       = IFQ_DEPTH
) (
  input logic                clock,
  input logic                reset_n,
  instr_fetch_queue_if.slave bus
);

  localparam int PW = ifq_clog2(DEPTH);

  logic                   inflight_q, inflight_d;
  logic [ADDR_W_IMEM-1:0] pend_addr_q, pend_addr_d;

  logic [PW:0]            count;
  logic                   full;
  logic                   empty;
  ifq_entry_t             head;
  ifq_entry_t             resp;
  ifq_entry_t             out_entry;
  logic [DATA_W-1:0]      rdata;
  logic [PW+1:0]          credit_used;
  logic                   issue;
  logic                   resp_valid;
  logic                   bypass;
  logic                   push;
  logic                   pop;

  // Issue when occupancy plus the read still in flight leaves a free slot,
  // so every returning word is guaranteed a place in the queue.
  always_comb begin
    credit_used   = {1'b0, count} + {{(PW+1){1'b0}}, inflight_q};
    issue         = reset_n & ~bus.flush & ~full &
                    (credit_used < (PW+2)'(DEPTH));
    bus.imem_rd   = issue;
    bus.pc_en     = issue;
    bus.imem_addr = bus.pc_addr;
    inflight_d    = issue;
    pend_addr_d   = issue ? bus.pc_addr : pend_addr_q;
  end

  // In-flight read tracking: the address travels alongside the IMEM access.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef IFQ_BYPASS_EN
  // Empty queue: the arriving response goes straight to decode.
  always_comb begin
    bypass = resp_valid & empty;
  end
`else
  // Every response is written to the queue before decode sees it.
  always_comb begin
    bypass = 1'b0;
  end
`endif

  // Response capture, queue control and decode-side output mux.
  always_comb begin
    rdata         = bus.imem_rdata;
    resp.addr     = pend_addr_q;
    resp.instr    = rdata;
    resp_valid    = inflight_q & ~bus.flush & reset_n;
    push          = resp_valid & ~(bypass & bus.out_ready);
    pop           = ~empty & bus.out_ready;
    bus.out_valid = ~empty | bypass;
    if (bypass) begin
      out_entry = resp;
    end else if (!empty) begin
      out_entry = head;
    end else begin
      out_entry = '0;
    end
    bus.out_addr  = out_entry.addr;
    bus.out_instr = out_entry.instr;
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .clr       (bus.flush),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule
